// File: rtl/cve2_mac_operand_seq.sv
// Operand sequencer and writeback for the MAC instruction (rd = rs1 * rs2 + rd).
// Captures operands, drives the shared multiplier, then re-uses the ALU adder for the accumulate.
//
// state | meaning
// IDLE  | waiting for a MAC in ID
// MUL   | multiplier busy with a_q * b_q, waiting for mul_valid_i
// ADD   | ALU adds prod_q + c_q, result written to rd this cycle
module cve2_mac_operand_seq #(
    parameter int unsigned Width    = 32,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mac_start_i,
    input  logic             flush_i,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  logic [Width-1:0] operand_c_i,
    input  logic [Width-1:0] mul_result_i,
    input  logic             mul_valid_i,
    input  logic [Width-1:0] alu_result_i,
    output logic             mul_en_o,
    output logic [Width-1:0] mul_op_a_o,
    output logic [Width-1:0] mul_op_b_o,
    output logic             alu_override_o,
    output logic [Width-1:0] alu_op_a_o,
    output logic [Width-1:0] alu_op_b_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic             rf_we_o,
    output logic [Width-1:0] rf_wdata_o,
    output logic             overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_e;

    localparam logic [Width-1:0] MaxPos = {1'b0, {(Width - 1) {1'b1}}};
    localparam logic [Width-1:0] MinNeg = {1'b1, {(Width - 1) {1'b0}}};

    state_e           state_q;
    state_e           state_d;
    logic [Width-1:0] a_q;
    logic [Width-1:0] b_q;
    logic [Width-1:0] c_q;
    logic [Width-1:0] prod_q;
    logic             start;
    logic             acc_ovf;
    logic [Width-1:0] sat_value;

    assign start = mac_start_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and product capture; a flush leaves the registers untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            prod_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                a_q <= operand_a_i;
                b_q <= operand_b_i;
                c_q <= operand_c_i;
            end
            if (state_q == MUL && mul_valid_i && !flush_i) begin
                prod_q <= mul_result_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (mul_valid_i) state_d = ADD;
            ADD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Signed overflow of prod_q + c_q: same-sign operands, different-sign sum.
    assign acc_ovf   = (prod_q[Width-1] == c_q[Width-1]) &&
                       (alu_result_i[Width-1] != prod_q[Width-1]);
    assign sat_value = prod_q[Width-1] ? MinNeg : MaxPos;

    always_comb begin
        mul_en_o       = 1'b0;
        mul_op_a_o     = '0;
        mul_op_b_o     = '0;
        alu_override_o = 1'b0;
        alu_op_a_o     = '0;
        alu_op_b_o     = '0;
        stall_o        = 1'b0;
        rf_we_o        = 1'b0;
        rf_wdata_o     = '0;
        overflow_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall_o = start && rst_ni;
            end
            MUL: begin
                mul_en_o   = !flush_i;
                mul_op_a_o = a_q;
                mul_op_b_o = b_q;
                stall_o    = !flush_i;
            end
            ADD: begin
                alu_override_o = !flush_i;
                alu_op_a_o     = prod_q;
                alu_op_b_o     = c_q;
                rf_we_o        = !flush_i;
                overflow_o     = acc_ovf;
                rf_wdata_o     = (Saturate && acc_ovf) ? sat_value : alu_result_i;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_cve2_mac_operand_seq.sv
// Scoreboard bench for cve2_mac_operand_seq: a wrapping and a saturating instance share stimulus,
// the bench plays multiplier and ALU, and a monitor checks every register-file write.
module tb_cve2_mac_operand_seq;

    localparam longint MaxI = 64'sh7FFF_FFFF;
    localparam longint MinI = -MaxI - 1;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mac_start, flush, mul_valid;
    logic [31:0] op_a, op_b, op_c;

    logic        mul_en0, alu_ovr0, stall0, busy0, rf_we0, ovf0;
    logic [31:0] mul_op_a0, mul_op_b0, alu_op_a0, alu_op_b0, rf_wdata0, mul_res0, alu_res0;
    logic        mul_en1, alu_ovr1, stall1, busy1, rf_we1, ovf1;
    logic [31:0] mul_op_a1, mul_op_b1, alu_op_a1, alu_op_b1, rf_wdata1, mul_res1, alu_res1;

    // Bench-side multiplier (low half only) and ALU adder.
    assign mul_res0 = mul_op_a0 * mul_op_b0;
    assign mul_res1 = mul_op_a1 * mul_op_b1;
    assign alu_res0 = alu_op_a0 + alu_op_b0;
    assign alu_res1 = alu_op_a1 + alu_op_b1;

    always #5 clk_i = ~clk_i;

    cve2_mac_operand_seq #(.Width(32), .Saturate(1'b0)) dut_wrap (
        .clk_i(clk_i), .rst_ni(rst_ni), .mac_start_i(mac_start), .flush_i(flush),
        .operand_a_i(op_a), .operand_b_i(op_b), .operand_c_i(op_c),
        .mul_result_i(mul_res0), .mul_valid_i(mul_valid), .alu_result_i(alu_res0),
        .mul_en_o(mul_en0), .mul_op_a_o(mul_op_a0), .mul_op_b_o(mul_op_b0),
        .alu_override_o(alu_ovr0), .alu_op_a_o(alu_op_a0), .alu_op_b_o(alu_op_b0),
        .stall_o(stall0), .busy_o(busy0), .rf_we_o(rf_we0), .rf_wdata_o(rf_wdata0),
        .overflow_o(ovf0)
    );

    cve2_mac_operand_seq #(.Width(32), .Saturate(1'b1)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .mac_start_i(mac_start), .flush_i(flush),
        .operand_a_i(op_a), .operand_b_i(op_b), .operand_c_i(op_c),
        .mul_result_i(mul_res1), .mul_valid_i(mul_valid), .alu_result_i(alu_res1),
        .mul_en_o(mul_en1), .mul_op_a_o(mul_op_a1), .mul_op_b_o(mul_op_b1),
        .alu_override_o(alu_ovr1), .alu_op_a_o(alu_op_a1), .alu_op_b_o(alu_op_b1),
        .stall_o(stall1), .busy_o(busy1), .rf_we_o(rf_we1), .rf_wdata_o(rf_wdata1),
        .overflow_o(ovf1)
    );

    typedef struct {
        logic [31:0] wrap;
        logic [31:0] sat;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    int          wr_cyc[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_exp    = 0;
    int          n_writes = 0;
    int          cyc      = 0;
    logic [31:0] last_wrap, last_sat;
    logic        last_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: full-precision signed arithmetic, then wrap or clamp.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        exp_t        e;
        logic [63:0] full;
        int          p;
        int          cs;
        longint      s;
        full   = {32'd0, a} * {32'd0, b};
        p      = $signed(full[31:0]);
        cs     = $signed(c);
        s      = longint'(p) + longint'(cs);
        e.wrap = s[31:0];
        e.ovf  = (s > MaxI) || (s < MinI);
        e.sat  = !e.ovf ? e.wrap : (s > 0 ? 32'h7FFF_FFFF : 32'h8000_0000);
        return e;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: every write pops one expected result.
    always @(negedge clk_i) begin
        if (rst_ni && (rf_we0 || rf_we1)) begin
            exp_t e;
            chkb("we_pair", rf_we0 && rf_we1, 1'b1);
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got data %h expected no write (t=%0t)", rf_wdata0, $time);
            end else begin
                e = sb_q.pop_front();
                chk("wdata_wrap", rf_wdata0, e.wrap);
                chk("wdata_sat", rf_wdata1, e.sat);
                chkb("ovf_wrap", ovf0, e.ovf);
                chkb("ovf_sat", ovf1, e.ovf);
            end
            last_wrap = rf_wdata0;
            last_sat  = rf_wdata1;
            last_ovf  = ovf0;
            n_writes++;
            wr_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // abort: 0 = complete, k in 1..n = flush in MUL cycle k, -1 = async reset during ADD.
    // junk drives a spurious mac_start with random operands while the MAC is in flight.
    task automatic run_mac(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input int n, input int abort, input bit junk);
        mac_start = 1'b1;
        flush     = 1'b0;
        op_a      = a;
        op_b      = b;
        op_c      = c;
        if (abort == 0) begin
            sb_q.push_back(model(a, b, c));
            n_exp++;
        end
        #3 chkb("stall_start", stall0, 1'b1);
        step();
        for (int i = 1; i <= n; i++) begin
            mac_start = junk;
            if (junk) begin
                op_a = $urandom;
                op_b = $urandom;
                op_c = $urandom;
            end
            mul_valid = (i == n);
            if (i == abort) begin
                flush = 1'b1;
                #3;
                chkb("flush_stall", stall0, 1'b0);
                chkb("flush_mul_en", mul_en0, 1'b0);
                chkb("flush_we", rf_we0, 1'b0);
                step();
                flush     = 1'b0;
                mul_valid = 1'b0;
                mac_start = 1'b0;
                chkb("flush_idle", busy0, 1'b0);
                return;
            end
            #3;
            chkb("mul_stall", stall0, 1'b1);
            chkb("mul_en", mul_en0, 1'b1);
            chkb("mul_busy", busy0, 1'b1);
            step();
        end
        mul_valid = 1'b0;
        if (abort < 0) begin
            #2;
            mac_start = 1'b0;
            rst_ni    = 1'b0;
            #1;
            chkb("rst_add_we", rf_we0, 1'b0);
            chkb("rst_add_outs", |{mul_en0, mul_op_a0, mul_op_b0, alu_ovr0, alu_op_a0, alu_op_b0,
                                    stall0, busy0, rf_we0, rf_wdata0, ovf0}, 1'b0);
            step();
            chkb("rst_hold_outs", |{mul_en1, mul_op_a1, mul_op_b1, alu_ovr1, alu_op_a1, alu_op_b1,
                                     stall1, busy1, rf_we1, rf_wdata1, ovf1}, 1'b0);
            rst_ni = 1'b1;
            return;
        end
        #3;
        chkb("add_we", rf_we0, 1'b1);
        chkb("add_stall", stall0, 1'b0);
        chkb("add_override", alu_ovr0, 1'b1);
        step();
        mac_start = 1'b0;
    endtask

    initial begin
        rst_ni    = 1'b0;
        mac_start = 1'b0;
        flush     = 1'b0;
        mul_valid = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_c      = '0;
        #12;
        chkb("reset_outs", |{mul_en0, mul_op_a0, mul_op_b0, alu_ovr0, alu_op_a0, alu_op_b0,
                              stall0, busy0, rf_we0, rf_wdata0, ovf0}, 1'b0);
        step();
        rst_ni = 1'b1;
        step();

        run_mac(32'd3, 32'd4, 32'd10, 1, 0, 1'b0);
        chk("basic_data", last_wrap, 32'd22);
        chkb("basic_ovf", last_ovf, 1'b0);

        run_mac(32'hFFFF_FFFF, 32'd5, 32'd2, 3, 0, 1'b0);
        chk("multi_data", last_wrap, 32'hFFFF_FFFD);

        run_mac(32'h7FFF_FFF0, 32'd1, 32'h20, 1, 0, 1'b0);
        chk("ovf_wrap_data", last_wrap, 32'h8000_0010);
        chk("ovf_sat_data", last_sat, 32'h7FFF_FFFF);
        chkb("ovf_flag", last_ovf, 1'b1);

        run_mac(32'd11, 32'd12, 32'd13, 2, 1, 1'b0);
        run_mac(32'd6, 32'd7, 32'd8, 1, 0, 1'b0);
        chk("after_flush_data", last_wrap, 32'd50);

        run_mac(32'd2, 32'd3, 32'd1, 1, 0, 1'b0);
        run_mac(32'd5, 32'd5, 32'd0, 1, 0, 1'b0);
        chk("b2b_data", last_wrap, 32'd25);
        chk("b2b_gap", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2]), 32'd3);

        mac_start = 1'b1;
        flush     = 1'b1;
        #3 chkb("start_flush_stall", stall0, 1'b0);
        step();
        mac_start = 1'b0;
        flush     = 1'b0;
        chkb("start_flush_idle", busy0, 1'b0);

        run_mac(32'd1, 32'd2, 32'd3, 1, -1, 1'b0);
        step();
        run_mac(32'd9, 32'd9, 32'd9, 2, 0, 1'b1);
        chk("after_reset_data", last_wrap, 32'd90);

        for (int k = 0; k < 80; k++) begin
            int n;
            int ab;
            n  = $urandom_range(1, 4);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, n) : 0;
            run_mac(pick(), pick(), pick(), n, ab, $urandom_range(0, 2) == 0);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("write_count", 32'(n_writes), 32'(n_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cve2_mac_operand_seq.md
# cve2_mac_operand_seq

Operand sequencer and writeback stage for the CVE2 multiply-accumulate instruction (rd = rs1 * rs2 + rd). It sits between the ID-stage decoder and the shared multiplier/ALU datapath. It captures the three source operands, drives the multiplier, holds the product, and re-presents product and accumulator to the ALU adder. It stalls ID until the single register-file write of the result.

## Interface
- Width, 32: datapath width in bits.
- Saturate, 0: 1 = clamp signed overflow of the accumulate step; 0 = wrap.

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- mac_start_i  in  1  MAC instruction valid in ID (decoded ALU_MAC with MAC enabled)
- flush_i  in  1  pipeline flush (exception/branch); aborts an in-flight MAC
- operand_a_i / operand_b_i  in  Width  rs1 / rs2 values
- operand_c_i  in  Width  rd (accumulator) value
- mul_result_i  in  Width  multiplier result, low Width bits
- mul_valid_i  in  1  mul_result_i valid this cycle
- alu_result_i  in  Width  ALU adder result
- mul_en_o  out  1  request multiplication of mul_op_a_o * mul_op_b_o
- mul_op_a_o / mul_op_b_o  out  Width  multiplier operands
- alu_override_o  out  1  ALU must use alu_op_a_o/alu_op_b_o and perform ADD
- alu_op_a_o / alu_op_b_o  out  Width  adder operands (product, accumulator)
- stall_o  out  1  hold ID stage
- busy_o  out  1  MAC in flight (state != IDLE)
- rf_we_o  out  1  register-file write enable for rd
- rf_wdata_o  out  Width  result to rd
- overflow_o  out  1  signed overflow of the accumulate step (valid with rf_we_o)

## Operation
- States: IDLE, MUL, ADD.
- IDLE:
  - On mac_start_i && !flush_i, register a_q, b_q, c_q from operand inputs; go to MUL.
  - stall_o = mac_start_i && !flush_i (combinational).
  - mac_start_i in any state other than IDLE is ignored.
- MUL:
  - mul_en_o = 1, mul_op_a_o = a_q, mul_op_b_o = b_q; stall_o = 1.
  - Remain in MUL until mul_valid_i; multi-cycle multipliers are supported.
  - On mul_valid_i, register prod_q = mul_result_i; go to ADD.
- ADD:
  - alu_override_o = 1, alu_op_a_o = prod_q, alu_op_b_o = c_q.
  - rf_we_o = 1; stall_o = 0, so the instruction retires this cycle; go to IDLE.
- Overflow, evaluated in ADD:
  - overflow_o = (prod_q[W-1] == c_q[W-1]) && (alu_result_i[W-1] != prod_q[W-1]).
- Write data:
  - Saturate = 0: rf_wdata_o = alu_result_i.
  - Saturate = 1 with overflow: rf_wdata_o = 0x7FF..F if prod_q is non-negative, 0x800..0 if negative; otherwise alu_result_i.
- Product is truncated to Width bits; the upper half is discarded.
- Outside the states listed above, mul_en_o, alu_override_o, rf_we_o and overflow_o are 0, and all data outputs are 0.
- flush_i in any state:
  - Next state is IDLE.
  - Same cycle: rf_we_o, mul_en_o, alu_override_o and stall_o are forced to 0.
  - Captured registers are left unchanged; they are don't-care afterwards.
- flush_i together with mac_start_i in IDLE: no capture, and the state stays IDLE.

## Timing
- Reset: state IDLE; a_q, b_q, c_q, prod_q = 0; every output = 0.
- Reset asserted mid-operation returns the block to IDLE immediately, with no write.
- Latency with a single-cycle multiplier (mul_valid_i in the first MUL cycle):
  - T0 start (stall)
  - T1 MUL (stall)
  - T2 ADD (write, no stall)
  - T3 IDLE, ready for a new start
- General latency: 2 + N cycles from start to write, where N is the number of MUL cycles.
- Back-to-back MACs: the second MAC, presented at T3, starts normally. There is no bubble beyond the instruction's own cycles.
- Exactly one rf_we_o pulse per non-flushed MAC.

## Test plan
- Basic: a = 3, b = 4, c = 10, single-cycle multiplier -> stall_o high at T0 and T1; rf_we_o at T2 with rf_wdata_o = 22; overflow_o = 0.
- Multi-cycle multiplier: mul_valid_i asserted 3 cycles after entering MUL, with a = 0xFFFFFFFF (-1), b = 5, c = 2 -> stall_o held 4 cycles; write value 0xFFFFFFFD (-3).
- Overflow, Saturate = 1: prod = 0x7FFFFFF0, c = 0x20 -> overflow_o = 1, rf_wdata_o = 0x7FFFFFFF. Same stimulus with Saturate = 0 -> rf_wdata_o = 0x80000010.
- Flush in MUL: flush_i pulsed in the MUL cycle -> no rf_we_o; state returns to IDLE; stall_o = 0 the same cycle. A following MAC completes correctly.
- Back-to-back: two MACs issued consecutively (2*3 + 1, then 5*5 + 0) -> two rf_we_o pulses, exactly 3 cycles apart, with data 7 and 25.
- Async reset asserted during ADD -> rf_we_o drops immediately, and all outputs are 0 while rst_ni is low.
